// File: rtl/bill_seg_display.sv
// bill_seg_display
//   Converts the 8-bit bill total to BCD with a sequential shift-add-3 engine
//   and drives a 4-digit common-anode multiplexed seven-segment display with
//   leading-zero blanking.
// Ports:
//   Clk   board clock, all state on rising edge
//   Rst   asynchronous active-low reset
//   Bill  unsigned bill total (0-255), registered once on entry
//   An    digit anodes, active-low (An[0] = units, An[3] = always blank)
//   Seg   segments {g,f,e,d,c,b,a}, active-low
//   Dp    decimal point, active-low, held off
//   Busy  high while a BCD conversion is in progress
module bill_seg_display #(
   parameter logic [15:0] REFRESH_DIV = 16'd50000
) (
   input  logic       Clk,
   input  logic       Rst,
   input  logic [7:0] Bill,
   output logic [3:0] An,
   output logic [6:0] Seg,
   output logic       Dp,
   output logic       Busy
);

   typedef enum logic [1:0] {IDLE, LOAD, SHIFT, DONE} state_t;

   state_t      state;
   state_t      state_nxt;
   logic        first;
   logic [7:0]  bill_q;
   logic [7:0]  conv_src;
   logic [19:0] sr;
   logic [19:0] sr_adj;
   logic [19:0] sr_step;
   logic [2:0]  cnt;
   logic [3:0]  disp_h;
   logic [3:0]  disp_t;
   logic [3:0]  disp_u;
   logic [15:0] refresh;
   logic [1:0]  idx;
   logic [6:0]  seg_nxt;

   function automatic logic [3:0] add3(input logic [3:0] n);
      return (n >= 4'd5) ? n + 4'd3 : n;
   endfunction

   function automatic logic [6:0] seg_code(input logic [3:0] d);
      logic [6:0] s;
      case (d)
         4'd0:    s = 7'b1000000;
         4'd1:    s = 7'b1111001;
         4'd2:    s = 7'b0100100;
         4'd3:    s = 7'b0110000;
         4'd4:    s = 7'b0011001;
         4'd5:    s = 7'b0010010;
         4'd6:    s = 7'b0000010;
         4'd7:    s = 7'b1111000;
         4'd8:    s = 7'b0000000;
         4'd9:    s = 7'b0010000;
         default: s = 7'b1111111;
      endcase
      return s;
   endfunction

   // One shift-add-3 step on {hundreds, tens, units, bin}
   always_comb begin
      sr_adj  = {add3(sr[19:16]), add3(sr[15:12]), add3(sr[11:8]), sr[7:0]};
      sr_step = {sr_adj[18:0], 1'b0};
   end

   // State register; 'first' forces one conversion right after reset so
   // Bill = 0 still ends up displayed.
   always_ff @(posedge Clk or negedge Rst) begin
      if (!Rst) begin
         state <= IDLE;
         first <= 1'b1;
      end else begin
         state <= state_nxt;
         first <= 1'b0;
      end
   end

   always_comb begin
      state_nxt = state;
      case (state)
         IDLE:    if (first || (bill_q != conv_src)) state_nxt = LOAD;
         LOAD:    state_nxt = SHIFT;
         SHIFT:   if (cnt == 3'd7) state_nxt = DONE;
         DONE:    state_nxt = IDLE;
         default: state_nxt = IDLE;
      endcase
   end

   assign Busy = (state != IDLE);
   assign Dp   = 1'b1;

   // Conversion datapath. The display registers are written from the final
   // shift result on the edge that enters DONE, so they only ever hold a
   // complete conversion.
   always_ff @(posedge Clk or negedge Rst) begin
      if (!Rst) begin
         bill_q   <= 8'd0;
         conv_src <= 8'd0;
         sr       <= 20'd0;
         cnt      <= 3'd0;
         disp_h   <= 4'd0;
         disp_t   <= 4'd0;
         disp_u   <= 4'd0;
      end else begin
         bill_q <= Bill;
         case (state)
            LOAD: begin
               conv_src <= bill_q;
               sr       <= {12'd0, bill_q};
               cnt      <= 3'd0;
            end
            SHIFT: begin
               sr  <= sr_step;
               cnt <= cnt + 3'd1;
               if (cnt == 3'd7) begin
                  disp_h <= sr_step[19:16];
                  disp_t <= sr_step[15:12];
                  disp_u <= sr_step[11:8];
               end
            end
            default: ;
         endcase
      end
   end

   // Segment content for the currently selected digit, with leading-zero
   // blanking of tens and hundreds.
   always_comb begin
      seg_nxt = 7'b1111111;
      case (idx)
         2'd0: seg_nxt = seg_code(disp_u);
         2'd1: if (!(disp_h == 4'd0 && disp_t == 4'd0)) seg_nxt = seg_code(disp_t);
         2'd2: if (disp_h != 4'd0) seg_nxt = seg_code(disp_h);
         default: seg_nxt = 7'b1111111;
      endcase
   end

   // Scan: An and Seg are registered together so they switch on the same edge.
   always_ff @(posedge Clk or negedge Rst) begin
      if (!Rst) begin
         refresh <= 16'd0;
         idx     <= 2'd0;
         An      <= 4'b1111;
         Seg     <= 7'b1111111;
      end else begin
         if (refresh == REFRESH_DIV - 16'd1) begin
            refresh <= 16'd0;
            idx     <= idx + 2'd1;
         end else begin
            refresh <= refresh + 16'd1;
         end
         An  <= ~(4'b0001 << idx);
         Seg <= seg_nxt;
      end
   end

endmodule
